// File: rtl/ntt_seq_ctrl_pkg.sv
// Shared constants and state encoding for the NTT sequencer.
package ntt_seq_ctrl_pkg;

  localparam int Addrwidth   = 8;
  localparam int Stagebnum   = Addrwidth;

  localparam int N_DEF       = 1 << Addrwidth;
  localparam int ADDR_W_DEF  = Addrwidth;
  localparam int STAGES_DEF  = Stagebnum;
  localparam int GAP_CYC_DEF = 4;
  localparam int STAGE_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GO,
    S_WAIT_STG,
    S_GAP,
    S_UNLOAD,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/ntt_unload_port.sv
// Unload stream over a 1-cycle-latency RAM read with consumer back-pressure.
// addr tags the word on the data bus; a rd_en raised during a handshake fetches addr+1.
module ntt_unload_port
  import ntt_seq_ctrl_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              hs;

  assign hs    = valid_q & ready;
  assign last  = valid_q & (addr_q == ADDR_W'(N - 1));
  assign addr  = addr_q;
  assign valid = valid_q;

  always_comb begin
    addr_d  = addr_q;
    valid_d = valid_q;
    rd_en   = 1'b0;
    if (start) begin
      addr_d  = '0;
      valid_d = 1'b1;
      rd_en   = 1'b1;
    end else if (hs) begin
      // final index wraps to 0, leaving the port ready for the next transform
      addr_d = addr_q + ADDR_W'(1);
      if (last) valid_d = 1'b0;
      else      rd_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/ntt_seq_ctrl.sv
// NTT top-level sequencer: load, per-stage launch with ping-pong bank select,
// then unload of the result bank.
module ntt_seq_ctrl
  import ntt_seq_ctrl_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int STAGES  = STAGES_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               ld_valid,
  output logic               ld_ready,
  output logic               ld_we,
  output logic [ADDR_W-1:0]  ld_addr,
  output logic               stage_go,
  input  logic               stage_done,
  output logic [STAGE_W-1:0] stage,
  output logic               src_sel,
  output logic               dp_own,
  output logic               ul_rd_en,
  output logic [ADDR_W-1:0]  ul_addr,
  output logic               ul_valid,
  input  logic               ul_ready,
  output logic               proto_err
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [ADDR_W-1:0]  LD_LAST  = ADDR_W'(N - 1);
  localparam logic [STAGE_W-1:0] STG_LAST = STAGE_W'(STAGES - 1);

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  ld_addr_q, ld_addr_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               src_sel_q, src_sel_d;
  logic               err_q, err_d;
  logic               ul_start_q, ul_start_d;
  logic               ul_last;

  assign ld_we     = ld_valid & ld_ready;
  assign ld_addr   = ld_addr_q;
  assign stage     = stage_q;
  assign src_sel   = src_sel_q;
  assign proto_err = err_q;

  always_comb begin
    state_d    = state_q;
    ld_addr_d  = ld_addr_q;
    stage_d    = stage_q;
    gap_d      = gap_q;
    src_sel_d  = src_sel_q;
    err_d      = err_q;
    ul_start_d = 1'b0;
    busy       = (state_q != S_IDLE);
    ld_ready   = 1'b0;
    stage_go   = 1'b0;
    dp_own     = 1'b0;
    done       = 1'b0;

    if (stage_done && (state_q != S_WAIT_STG)) err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          ld_addr_d = '0;
          stage_d   = '0;
          src_sel_d = 1'b0;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          ld_addr_d = ld_addr_q + ADDR_W'(1);
          if (ld_addr_q == LD_LAST) state_d = S_GO;
        end
      end
      S_GO: begin
        stage_go = 1'b1;
        dp_own   = 1'b1;
        state_d  = S_WAIT_STG;
      end
      S_WAIT_STG: begin
        dp_own = 1'b1;
        if (stage_done) begin
          // the stage just written becomes the next read source
          src_sel_d = ~src_sel_q;
          if (stage_q == STG_LAST) begin
            state_d    = S_UNLOAD;
            ul_start_d = 1'b1;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
            gap_d   = '0;
            state_d = (GAP_CYC == 0) ? S_GO : S_GAP;
          end
        end
      end
      S_GAP: begin
        dp_own = 1'b1;
        if (gap_q == GAP_LAST) state_d = S_GO;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      S_UNLOAD: begin
        if (ul_valid && ul_ready && ul_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ld_addr_q  <= '0;
      stage_q    <= '0;
      gap_q      <= '0;
      src_sel_q  <= 1'b0;
      err_q      <= 1'b0;
      ul_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_addr_q  <= ld_addr_d;
      stage_q    <= stage_d;
      gap_q      <= gap_d;
      src_sel_q  <= src_sel_d;
      err_q      <= err_d;
      ul_start_q <= ul_start_d;
    end
  end

  ntt_unload_port #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_unload (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ul_start_q),
    .ready (ul_ready),
    .rd_en (ul_rd_en),
    .addr  (ul_addr),
    .valid (ul_valid),
    .last  (ul_last)
  );

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Event-level reference bench for ntt_seq_ctrl with randomized stream timing.
module tb_ntt_seq_ctrl;

  localparam int N       = 256;
  localparam int ADDR_W  = 8;
  localparam int STAGES  = 8;
  localparam int GAP_CYC = 4;
  localparam int INF     = 1000000000;
  localparam int BUDGET  = 5000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              ld_valid = 1'b0;
  logic              stage_done = 1'b0;
  logic              ul_ready = 1'b0;
  logic              busy, done, ld_ready, ld_we, stage_go, src_sel, dp_own;
  logic              ul_rd_en, ul_valid, proto_err;
  logic [ADDR_W-1:0] ld_addr, ul_addr;
  logic [4:0]        stage;

  int total = 0;
  int bad   = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  ntt_seq_ctrl #(.N(N), .ADDR_W(ADDR_W), .STAGES(STAGES), .GAP_CYC(GAP_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .stage_go   (stage_go),
    .stage_done (stage_done),
    .stage      (stage),
    .src_sel    (src_sel),
    .dp_own     (dp_own),
    .ul_rd_en   (ul_rd_en),
    .ul_addr    (ul_addr),
    .ul_valid   (ul_valid),
    .ul_ready   (ul_ready),
    .proto_err  (proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_src_sel"}, src_sel, 0);
    chk({tag, "_dp_own"}, dp_own, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_ul_valid"}, ul_valid, 0);
  endtask

  // One transform, observed cycle by cycle against event-derived expectations.
  // ld_mode: 0 always valid, 1 toggling, 2 random. ul_mode: 0 always ready, 1 random.
  task automatic run(input int ld_mode, input int ul_mode, input int dmin, input int dmax,
                     input bit stall17, input bit spur, input bit rst_mid,
                     input bit start_ul, input bit chk_total);
    int  cyc, m_loaded, m_go, m_sd, m_hs;
    int  go_exp, go_first, ul_start, done_exp, sd_at, rst_cyc, spur_cyc;
    int  stall_left, done_cnt, done_cyc;
    bit  exp_ldr, exp_valid, exp_rd;
    cyc = 0; m_loaded = 0; m_go = 0; m_sd = 0; m_hs = 0;
    go_exp = INF; go_first = INF; ul_start = INF; done_exp = INF; sd_at = INF;
    rst_cyc = INF; spur_cyc = INF; stall_left = 5; done_cnt = 0; done_cyc = -1;
    while (cyc < BUDGET) begin
      @(negedge clk);
      exp_valid  = (cyc > ul_start) && (m_hs < N);
      start      = (cyc == 0) || (start_ul && cyc == ul_start + 10);
      case (ld_mode)
        0:       ld_valid = 1'b1;
        1:       ld_valid = (cyc % 2 == 1);
        default: ld_valid = ($urandom_range(1, 0) == 1);
      endcase
      ul_ready = (ul_mode == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
      if (stall17 && exp_valid && m_hs == 17 && stall_left > 0) begin
        ul_ready = 1'b0;
        stall_left--;
      end
      stage_done = (cyc == sd_at);
      if (spur && spur_cyc == INF && m_loaded == 10) begin
        stage_done = 1'b1;
        spur_cyc   = cyc;
      end
      rst_n = !(cyc == rst_cyc);
      #1;

      exp_ldr = (cyc >= 1) && (m_loaded < N);
      chk("busy", busy, (cyc >= 1) && (cyc <= done_exp));
      chk("ld_ready", ld_ready, exp_ldr);
      chk("ld_we", ld_we, ld_valid && exp_ldr);
      if (exp_ldr) chk("stage_in_load", stage, 0);
      if (ld_valid && exp_ldr) begin
        chk("ld_addr", ld_addr, m_loaded);
        m_loaded++;
        if (m_loaded == N) begin
          go_exp   = cyc + 1;
          go_first = cyc + 1;
        end
      end

      chk("stage_go", stage_go, cyc == go_exp);
      chk("dp_own", dp_own, (cyc >= go_first) && (cyc < ul_start));
      if (cyc == go_exp) begin
        chk("stage", stage, m_go);
        chk("src_sel_go", src_sel, m_go % 2);
        sd_at = cyc + $urandom_range(dmax, dmin);
        if (rst_mid && m_go == 3) rst_cyc = cyc + 5;
        m_go++;
      end
      if (cyc == sd_at) begin
        m_sd++;
        if (m_sd < STAGES) go_exp = cyc + GAP_CYC + 1;
        else               ul_start = cyc + 1;
      end

      exp_rd = (cyc == ul_start) || (exp_valid && ul_ready && m_hs < N - 1);
      chk("ul_valid", ul_valid, exp_valid);
      chk("ul_rd_en", ul_rd_en, exp_rd);
      if (cyc == ul_start) begin
        chk("ul_addr_entry", ul_addr, 0);
        chk("src_sel_result", src_sel, STAGES % 2);
      end
      if (exp_valid) chk("ul_addr", ul_addr, m_hs);
      if (exp_valid && ul_ready) begin
        m_hs++;
        if (m_hs == N) done_exp = cyc + 1;
      end

      chk("done", done, cyc == done_exp);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      chk("proto_err", proto_err, m_err);
      if (cyc == spur_cyc) m_err = 1'b1;

      if (cyc == rst_cyc) begin
        @(negedge clk);
        rst_n      = 1'b1;
        stage_done = 1'b0;
        start      = 1'b0;
        #1;
        m_err = 1'b0;
        chk_idle("mid_reset");
        return;
      end
      if (cyc == done_exp + 3) break;
      cyc++;
    end
    chk("finished_in_budget", cyc < BUDGET, 1);
    chk("done_count", done_cnt, 1);
    chk("stage_go_count", m_go, STAGES);
    if (chk_total)
      chk("latency", done_cyc, 1 + N + STAGES * (1 + dmin) + (STAGES - 1) * GAP_CYC + N + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    chk("reset_ld_addr", ld_addr, 0);
    chk("reset_ul_addr", ul_addr, 0);
    chk("reset_stage_go", stage_go, 0);
    // nominal run with a start pulse during unload
    run(0, 0, 131, 131, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    // load back-pressure
    run(1, 0, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // unload stall at index 17
    run(0, 0, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // spurious stage_done during load; proto_err stays set into the next run
    run(0, 0, 4, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // reset during stage 3
    run(0, 0, 40, 40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // clean transform after reset
    run(0, 0, 131, 131, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // randomized streams and stage durations
    repeat (2) run(2, 1, 1, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
